// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: iterative radix-2 shift-add multiplier.
// A single (WIDTH+1)-bit adder is reused over WIDTH steps to form a 2*WIDTH-bit product.
// The operation is launched by start and reported by a one-cycle done pulse.
// The product register holds its value until the next operation completes.
// Optional build macro SEQ_MULT_SIGNED_EN: operands and product are two's complement.
// In that build the core multiplies magnitudes and the sign is applied on completion.
module seq_shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     q,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      count_q, count_d;
    logic [PW-1:0]      product_q, product_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH:0]     sum_s;
    logic [PW-1:0]      mag_s;
`ifdef SEQ_MULT_SIGNED_EN
    logic               sign_q, sign_d;

    // Absolute value of a two's-complement operand. Reading the WIDTH-bit negation
    // as unsigned gives the true magnitude even for -2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] abs_fn(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (v[WIDTH-1]) begin
            r = ~v + WIDTH'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction
`endif

    // Datapath step and next-state logic for the start/run/done sequence
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        product_d = product_q;
`ifdef SEQ_MULT_SIGNED_EN
        sign_d    = sign_q;
`endif
        // Conditional add of the multiplicand, then {sum, mplier} shifted right one bit.
        sum_s = acc_q + ({1'b0, mcand_q} & {(WIDTH + 1){mplier_q[0]}});
        mag_s = {sum_s, mplier_q[WIDTH-1:1]};

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
`ifdef SEQ_MULT_SIGNED_EN
                    mcand_d  = abs_fn(m);
                    mplier_d = abs_fn(q);
                    sign_d   = m[WIDTH-1] ^ q[WIDTH-1];
`else
                    mcand_d  = m;
                    mplier_d = q;
`endif
                    acc_d    = {(WIDTH + 1){1'b0}};
                    count_d  = {CW{1'b0}};
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d    = {1'b0, sum_s[WIDTH:1]};
                mplier_d = {sum_s[0], mplier_q[WIDTH-1:1]};
                count_d  = count_q + CW'(1);
                if (count_q == LAST_STEP) begin
`ifdef SEQ_MULT_SIGNED_EN
                    if (sign_q && (mag_s != {PW{1'b0}})) begin
                        product_d = ~mag_s + PW'(1);
                    end else begin
                        product_d = mag_s;
                    end
`else
                    product_d = mag_s;
`endif
                    state_d   = S_DONE;
                end else begin
                    state_d   = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered, derived from the state being entered.
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and registered-output flops; reset aborts any operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= {(WIDTH + 1){1'b0}};
            mcand_q   <= {WIDTH{1'b0}};
            mplier_q  <= {WIDTH{1'b0}};
            count_q   <= {CW{1'b0}};
            product_q <= {PW{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q    <= sign_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: WIDTH=4 instance for directed cases,
// WIDTH=8 instance for a randomized sweep. Drivers push expected results into
// scoreboard queues; negedge monitors pop and compare on every done pulse.
module tb_seq_shift_add_multiplier;

    typedef struct {
        logic [15:0] prod;
        int          e0;    // cycle index of the accepting edge
        int          due;   // cycle index at which done must be seen
    } item_t;

    logic        clk = 1'b0;
    logic        rst4 = 1'b1, rst8 = 1'b1;
    logic        start4 = 1'b0, start8 = 1'b0;
    logic [3:0]  m4 = 4'd0, q4 = 4'd0;
    logic [7:0]  m8 = 8'd0, q8 = 8'd0;
    logic        busy4, done4, busy8, done8;
    logic [7:0]  product4;
    logic [15:0] product8;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    item_t sb4[$];
    item_t sb8[$];
    logic [7:0]  hold4 = 8'd0;
    logic [15:0] hold8 = 16'd0;

    seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .m(m4), .q(q4),
        .busy(busy4), .done(done4), .product(product4)
    );

    seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .m(m8), .q(q8),
        .busy(busy8), .done(done8), .product(product8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference multiply from plain integer arithmetic.
    function automatic logic [15:0] ref_mul(input int w, input logic [7:0] a, input logic [7:0] b);
        int x, y;
`ifdef SEQ_MULT_SIGNED_EN
        x = (a[w-1]) ? int'(a) - (1 << w) : int'(a);
        y = (b[w-1]) ? int'(b) - (1 << w) : int'(b);
`else
        x = int'(a);
        y = int'(b);
`endif
        return 16'((x * y) & ((1 << (2 * w)) - 1));
    endfunction

    // WIDTH=4 monitor
    always @(negedge clk) begin
        if (!rst4) begin
            chk("busy4", 32'(busy4),
                32'((sb4.size() > 0) && (cyc >= sb4[0].e0) && (cyc < sb4[0].due)));
            if (done4) begin
                if (sb4.size() == 0) begin
                    chk("unexpected_done4", 32'(done4), 32'd0);
                end else begin
                    item_t it;
                    it = sb4.pop_front();
                    chk("latency4", 32'(cyc), 32'(it.due));
                    chk("product4", 32'(product4), 32'(it.prod[7:0]));
                    hold4 = it.prod[7:0];
                end
            end else begin
                chk("hold4", 32'(product4), 32'(hold4));
                if ((sb4.size() > 0) && (cyc > sb4[0].due)) begin
                    chk("timeout4", 32'(cyc), 32'(sb4[0].due));
                    void'(sb4.pop_front());
                end
            end
        end
    end

    // WIDTH=8 monitor
    always @(negedge clk) begin
        if (!rst8) begin
            chk("busy8", 32'(busy8),
                32'((sb8.size() > 0) && (cyc >= sb8[0].e0) && (cyc < sb8[0].due)));
            if (done8) begin
                if (sb8.size() == 0) begin
                    chk("unexpected_done8", 32'(done8), 32'd0);
                end else begin
                    item_t it;
                    it = sb8.pop_front();
                    chk("latency8", 32'(cyc), 32'(it.due));
                    chk("product8", 32'(product8), 32'(it.prod));
                    hold8 = it.prod;
                end
            end else begin
                chk("hold8", 32'(product8), 32'(hold8));
                if ((sb8.size() > 0) && (cyc > sb8[0].due)) begin
                    chk("timeout8", 32'(cyc), 32'(sb8[0].due));
                    void'(sb8.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Drive one accepted op on the 4-bit unit; returns just after the accepting edge.
    task automatic op4(input logic [3:0] a, input logic [3:0] b);
        item_t it;
        start4 = 1'b1; m4 = a; q4 = b;
        it.e0 = cyc + 1; it.due = it.e0 + 4; it.prod = ref_mul(4, {4'd0, a}, {4'd0, b});
        sb4.push_back(it);
        step();
        start4 = 1'b0; m4 = 4'($urandom); q4 = 4'($urandom);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b);
        item_t it;
        start8 = 1'b1; m8 = a; q8 = b;
        it.e0 = cyc + 1; it.due = it.e0 + 8; it.prod = ref_mul(8, a, b);
        sb8.push_back(it);
        step();
        start8 = 1'b0; m8 = 8'($urandom); q8 = 8'($urandom);
    endtask

    task automatic wait4();
        for (int i = 0; i < 40; i++) begin
            if (sb4.size() == 0) break;
            step();
        end
        if (sb4.size() != 0) chk("wait4_bound", 32'(sb4.size()), 32'd0);
    endtask

    task automatic wait8();
        for (int i = 0; i < 40; i++) begin
            if (sb8.size() == 0) break;
            step();
        end
        if (sb8.size() != 0) chk("wait8_bound", 32'(sb8.size()), 32'd0);
    endtask

    initial begin
        item_t it;
        repeat (2) step();
        chk("rst_busy4", 32'(busy4), 32'd0);
        chk("rst_done4", 32'(done4), 32'd0);
        chk("rst_product4", 32'(product4), 32'd0);
        chk("rst_product8", 32'(product8), 32'd0);
        rst4 = 1'b0; rst8 = 1'b0;
        step();

        // 15*15, busy for exactly four cycles
        op4(4'hF, 4'hF);
        wait4();
        step();

        // 13*11 with a second start during RUN that must be ignored
        op4(4'd13, 4'd11);
        step();
        start4 = 1'b1; m4 = 4'd1; q4 = 4'd1;
        step();
        start4 = 1'b0;
        wait4();
        step();

        // 0*9, then start held through RUN and DONE: second op back-to-back
        op4(4'd0, 4'd9);
        start4 = 1'b1; m4 = 4'd7; q4 = 4'd3;
        it.e0 = sb4[0].due + 1; it.due = it.e0 + 4;
        it.prod = ref_mul(4, 8'd7, 8'd3);
        sb4.push_back(it);
        for (int i = 0; i < 20; i++) begin
            if (cyc >= it.e0) break;
            step();
        end
        start4 = 1'b0;
        wait4();
        step();

        // Reset after two steps of 15*15 aborts it
        op4(4'hF, 4'hF);
        step();
        step();
        rst4 = 1'b1;
        #1;
        chk("abort_busy4", 32'(busy4), 32'd0);
        chk("abort_done4", 32'(done4), 32'd0);
        chk("abort_product4", 32'(product4), 32'd0);
        sb4.delete();
        hold4 = 8'd0;
        step();
        rst4 = 1'b0;
        repeat (8) step();
        op4(4'd2, 4'd3);
        wait4();
        step();

        // Sign-sensitive operand patterns
        op4(4'hD, 4'd5);  wait4();
        op4(4'h8, 4'h8);  wait4();
        op4(4'h8, 4'd7);  wait4();
        step();

        // 8-bit boundary operands, then randomized sweep with random gaps
        op8(8'hFF, 8'hFF); wait8();
        op8(8'h80, 8'h80); wait8();
        op8(8'h80, 8'h7F); wait8();
        op8(8'h00, 8'hA5); wait8();
        for (int n = 0; n < 1000; n++) begin
            op8(8'($urandom), 8'($urandom));
            wait8();
            repeat ($urandom_range(0, 2)) step();
        end
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
